snes_controller: RTL and testbench



---
 rtl/snes_pkg.sv | 32 +++
 rtl/sync2.sv | 23 ++
 rtl/snes_controller.sv | 178 +++++++++++++++++
 tb/tb_snes_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/snes_pkg.sv
// Shared definitions for the SNES gamepad poller: FSM state encoding, button bit
// positions within the snesInput word, and default protocol timing at a 50 MHz clock.
package snes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT,
    LOW,
    HIGH,
    DONE
  } snesState_t;

  // Button positions in snesInput (1 = pressed); bits 15:12 always read 0.
  localparam int unsigned BTN_B      = 0;
  localparam int unsigned BTN_Y      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;
  localparam int unsigned BTN_A      = 8;
  localparam int unsigned BTN_X      = 9;
  localparam int unsigned BTN_L      = 10;
  localparam int unsigned BTN_R      = 11;

  localparam int unsigned DEFAULT_LATCH_CYCLES = 600;     // 12 us
  localparam int unsigned DEFAULT_HALF_CYCLES  = 300;     // 6 us
  localparam int unsigned DEFAULT_POLL_CYCLES  = 833333;  // 60 Hz

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports: clk (clock), reset (sync, active-high), d (async input), q (synchronized output).
// Resets to 1, the idle/released level of the pad data line.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_controller.sv
// SNES gamepad poller. Issues a latch strobe every POLL_CYCLES, clocks 16 bits out of the
// pad, and publishes a stable active-high 12-button word on snesInput.
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   snesData   serial pad data, active-low, asynchronous to clk
//   snesLatch  latch strobe to pad
//   snesClk    serial clock to pad, idles high
//   snesInput  button word, 1 = pressed, bits 15:12 always 0
//   update     one-cycle pulse coincident with a new snesInput value
// Build option: define SNES_DEBOUNCE_EN to publish a frame only when it matches the
// previous raw frame.
module snes_controller
  import snes_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int unsigned HALF_CYCLES  = DEFAULT_HALF_CYCLES,
  parameter int unsigned POLL_CYCLES  = DEFAULT_POLL_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snesData,
  output logic        snesLatch,
  output logic        snesClk,
  output logic [15:0] snesInput,
  output logic        update
);

  localparam int unsigned PollW    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PhaseMax = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned PhaseW   = (PhaseMax > 1) ? $clog2(PhaseMax) : 1;

  snesState_t        stateQ, stateD;
  logic [PollW-1:0]  pollQ, pollD;
  logic [PhaseW-1:0] phaseQ, phaseD;
  logic [3:0]        bitQ, bitD;
  logic [15:0]       shiftQ, shiftD;
  logic [15:0]       inputQ, inputD;
  logic              updateQ, updateD;
  logic              latchQ, clkQ;
  logic              dataSync;
  logic              pollLast, latchLast, halfLast;
  logic [15:0]       newWord;
`ifdef SNES_DEBOUNCE_EN
  logic [15:0]       prevQ, prevD;
`endif

  // Bits 15:12 are clocked out of the pad but never published.
  logic unusedShiftHi;
  assign unusedShiftHi = ^shiftQ[15:12];

  sync2 dataSyncer (
    .clk  (clk),
    .reset(reset),
    .d    (snesData),
    .q    (dataSync)
  );

  assign pollLast  = (pollQ == PollW'(POLL_CYCLES - 1));
  assign latchLast = (phaseQ == PhaseW'(LATCH_CYCLES - 1));
  assign halfLast  = (phaseQ == PhaseW'(HALF_CYCLES - 1));
  assign newWord   = {4'b0000, ~shiftQ[11:0]};

  always_comb begin
    stateD  = stateQ;
    phaseD  = phaseQ;
    bitD    = bitQ;
    shiftD  = shiftQ;
    inputD  = inputQ;
    updateD = 1'b0;
`ifdef SNES_DEBOUNCE_EN
    prevD   = prevQ;
`endif
    // Free-running so the frame start period is exactly POLL_CYCLES.
    pollD   = pollLast ? '0 : pollQ + 1'b1;

    case (stateQ)
      IDLE: begin
        if (pollLast) begin
          stateD = LATCH;
          phaseD = '0;
        end
      end
      LATCH: begin
        if (latchLast) begin
          stateD = WAIT;
          phaseD = '0;
          bitD   = '0;
        end else begin
          phaseD = phaseQ + 1'b1;
        end
      end
      WAIT: begin
        if (halfLast) begin
          shiftD[0] = dataSync;
          stateD    = LOW;
          phaseD    = '0;
        end else begin
          phaseD = phaseQ + 1'b1;
        end
      end
      LOW: begin
        if (halfLast) begin
          stateD = HIGH;
          phaseD = '0;
        end else begin
          phaseD = phaseQ + 1'b1;
        end
      end
      HIGH: begin
        if (halfLast) begin
          phaseD = '0;
          if (bitQ < 4'd15) begin
            bitD                       = bitQ + 4'd1;
            shiftD[4'(bitQ + 4'd1)]    = dataSync;
            stateD                     = LOW;
          end else begin
            stateD = DONE;
          end
        end else begin
          phaseD = phaseQ + 1'b1;
        end
      end
      DONE: begin
`ifdef SNES_DEBOUNCE_EN
        if (newWord == prevQ) begin
          inputD  = newWord;
          updateD = 1'b1;
        end
        prevD = newWord;
`else
        inputD  = newWord;
        updateD = 1'b1;
`endif
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  // Pad outputs are registered from the next state so they stay glitch-free yet line up
  // exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ  <= IDLE;
      pollQ   <= '0;
      phaseQ  <= '0;
      bitQ    <= '0;
      shiftQ  <= '0;
      inputQ  <= '0;
      updateQ <= 1'b0;
      latchQ  <= 1'b0;
      clkQ    <= 1'b1;
`ifdef SNES_DEBOUNCE_EN
      prevQ   <= '0;
`endif
    end else begin
      stateQ  <= stateD;
      pollQ   <= pollD;
      phaseQ  <= phaseD;
      bitQ    <= bitD;
      shiftQ  <= shiftD;
      inputQ  <= inputD;
      updateQ <= updateD;
      latchQ  <= (stateD == LATCH);
      clkQ    <= (stateD != LOW);
`ifdef SNES_DEBOUNCE_EN
      prevQ   <= prevD;
`endif
    end
  end

  assign snesLatch = latchQ;
  assign snesClk   = clkQ;
  assign snesInput = inputQ;
  assign update    = updateQ;

endmodule

// File: tb/tb_snes_controller.sv
// Scoreboard bench for snes_controller with short protocol timing and a behavioural pad.
module tb_snes_controller;

  localparam int unsigned Poll = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snesData;
  logic        snesLatch;
  logic        snesClk;
  logic [15:0] snesInput;
  logic        update;

  always #5 clk = ~clk;

  snes_controller #(
    .LATCH_CYCLES(4),
    .HALF_CYCLES (2),
    .POLL_CYCLES (Poll)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .snesData (snesData),
    .snesLatch(snesLatch),
    .snesClk  (snesClk),
    .snesInput(snesInput),
    .update   (update)
  );

  int nApplied = 0;
  int nMiscompares = 0;
  logic [15:0] expQ[$];

  // Pad model: pressed buttons drive 0. The next bit is presented on the falling snesClk
  // so it has settled through the two-flop synchronizer before the 2-cycle high phase ends.
  logic [15:0] padPressed = 16'h0000;
  bit          noPad = 1'b0;
  logic [15:0] padSr = 16'hFFFF;

  always @(posedge snesLatch) padSr = ~padPressed;
  always @(negedge snesClk) if (!snesLatch) padSr = {1'b1, padSr[15:1]};
  assign snesData = noPad ? 1'b1 : padSr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest queued expectation.
  logic prevUpd = 1'b0;
  always @(negedge clk) begin
    if (!reset && update) begin
      check("update_one_cycle", {31'b0, prevUpd}, 32'd0);
      if (expQ.size() == 0) begin
        nApplied++;
        nMiscompares++;
        $display("FAIL unexpected_update: got update with snesInput=%h, required none", snesInput);
      end else begin
        check("snesInput", {16'b0, snesInput}, {16'b0, expQ.pop_front()});
      end
    end
    prevUpd <= update;
  end

  task automatic waitUpdate(input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (update) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic runFrame(input string name, input logic [15:0] pressed, input logic [15:0] exp,
                          input bit checkPeriod);
    bit seen;
    int cycles;
    padPressed = pressed;
    expQ.push_back(exp);
    waitUpdate(400, seen, cycles);
    check({name, "_seen"}, {31'b0, seen}, 32'd1);
    if (seen && checkPeriod) check({name, "_period"}, cycles, Poll);
  endtask

  initial begin
    bit seen;
    int cycles;
    int n;
    int pulses;
    int badW;
    int curW;
    int falls;
    logic prevClk;

    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_latch", {31'b0, snesLatch}, 32'd0);
    check("rst_clk", {31'b0, snesClk}, 32'd1);
    check("rst_input", {16'b0, snesInput}, 32'd0);
    check("rst_update", {31'b0, update}, 32'd0);

    // First frame timing
    expQ.push_back(16'h0000);
    reset = 1'b0;
    n = 0;
    while (!snesLatch && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("first_latch_rise", n, 200);
    n = 0;
    while (snesLatch && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("latch_width", n, 4);
    pulses = 0;
    badW = 0;
    curW = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!snesClk) curW++;
      else if (curW != 0) begin
        pulses++;
        if (curW != 2) badW++;
        curW = 0;
      end
      if (update) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("first_update_seen", {31'b0, seen}, 32'd1);
    check("clk_low_pulses", pulses, 16);
    check("clk_low_widths_bad", badW, 0);

`ifndef SNES_DEBOUNCE_EN
    runFrame("a_only", 16'h0100, 16'h0100, 1'b1);
    runFrame("b_right", 16'h0081, 16'h0081, 1'b1);
    runFrame("all_pressed", 16'hFFFF, 16'h0FFF, 1'b1);
    noPad = 1'b1;
    runFrame("no_pad_1", 16'h0000, 16'h0000, 1'b1);
    runFrame("no_pad_2", 16'h0000, 16'h0000, 1'b1);
    noPad = 1'b0;

    // Reset during LOW of bit 7 with Start pressed
    padPressed = 16'h0008;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (snesLatch) break;
    end
    falls = 0;
    prevClk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!snesClk && prevClk) falls++;
      prevClk = snesClk;
      if (falls == 8) break;
    end
    check("reached_bit7_low", falls, 8);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_latch", {31'b0, snesLatch}, 32'd0);
    check("midrst_clk", {31'b0, snesClk}, 32'd1);
    check("midrst_input", {16'b0, snesInput}, 32'd0);
    check("midrst_update", {31'b0, update}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expQ.push_back(16'h0008);
    waitUpdate(400, seen, cycles);
    check("post_reset_seen", {31'b0, seen}, 32'd1);
    check("post_reset_latency", cycles, 271);
`else
    // Alternating frames must not publish; a repeated frame does.
    padPressed = 16'h0010;
    repeat (Poll) @(negedge clk);
    check("deb_hold_up", {16'b0, snesInput}, 32'd0);
    padPressed = 16'h0020;
    repeat (Poll) @(negedge clk);
    check("deb_hold_down", {16'b0, snesInput}, 32'd0);
    padPressed = 16'h0010;
    repeat (Poll) @(negedge clk);
    check("deb_hold_up2", {16'b0, snesInput}, 32'd0);
    runFrame("deb_up_up", 16'h0010, 16'h0010, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
